// File: rtl/bcd_field_counter_pkg.sv
// Shared constants and helpers for the BCD field counter: nibble geometry,
// parameter-to-BCD conversion and a digit-wise BCD comparison.
package bcd_field_counter_pkg;

    localparam int unsigned NibbleW   = 4;
    localparam logic [3:0]  DigitMax  = 4'd9;
    localparam int unsigned MaxDigits = 4;

    // Converts an elaboration-time integer into up to four packed BCD digits.
    function automatic logic [NibbleW*MaxDigits-1:0] int_to_bcd(input int unsigned value);
        logic [NibbleW*MaxDigits-1:0] bcd;
        int unsigned rem;
        bcd = '0;
        rem = value;
        for (int i = 0; i < MaxDigits; i++) begin
            bcd[NibbleW*i +: NibbleW] = 4'(rem % 10);
            rem = rem / 10;
        end
        return bcd;
    endfunction

    // a < b, deciding on the most-significant differing nibble.
    function automatic logic bcd_lt(input logic [NibbleW*MaxDigits-1:0] a,
                                    input logic [NibbleW*MaxDigits-1:0] b);
        logic lt;
        logic decided;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = MaxDigits - 1; i >= 0; i--) begin
            if (!decided && (a[NibbleW*i +: NibbleW] != b[NibbleW*i +: NibbleW])) begin
                lt      = a[NibbleW*i +: NibbleW] < b[NibbleW*i +: NibbleW];
                decided = 1'b1;
            end
        end
        return lt;
    endfunction

endpackage

// File: rtl/bcd_nibble_step.sv
// One BCD digit of the up/down chain: steps the digit when a carry or borrow
// arrives and ripples a carry/borrow to the next digit on roll-over.
module bcd_nibble_step
    import bcd_field_counter_pkg::*;
(
    input  logic [NibbleW-1:0] digit_i,
    input  logic               carry_i,
    input  logic               borrow_i,
    output logic [NibbleW-1:0] digit_o,
    output logic               carry_o,
    output logic               borrow_o
);

    always_comb begin
        digit_o  = digit_i;
        carry_o  = 1'b0;
        borrow_o = 1'b0;
        if (carry_i) begin
            // >= so a stray non-BCD code still lands back on a legal digit
            if (digit_i >= DigitMax) begin
                digit_o = '0;
                carry_o = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end else if (borrow_i) begin
            if (digit_i == '0) begin
                digit_o  = DigitMax;
                borrow_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_field_counter.sv
// Up/down BCD field counter (seconds, hours, days...) with a runtime ceiling,
// a parameter floor, wrap-or-saturate limits and same-cycle carry/borrow.
module bcd_field_counter
    import bcd_field_counter_pkg::*;
#(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned MIN_VALUE = 0,
    parameter int unsigned WRAP      = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        inc_i,
    input  logic                        dec_i,
    input  logic                        load_i,
    input  logic [NibbleW*DIGITS-1:0]   load_value_i,
    input  logic [NibbleW*DIGITS-1:0]   max_i,
    output logic [NibbleW*DIGITS-1:0]   value_o,
    output logic                        at_max_o,
    output logic                        at_min_o,
    output logic                        carry_o,
    output logic                        borrow_o,
    output logic                        load_err_o
);

    localparam int unsigned W    = NibbleW * DIGITS;
    localparam int unsigned ExtW = NibbleW * MaxDigits;

    localparam logic [ExtW-1:0] MinBcdFull = int_to_bcd(MIN_VALUE);
    localparam logic [W-1:0]    MinBcd     = MinBcdFull[W-1:0];

    logic [W-1:0]      value_q, value_d;
    logic              load_err_q, load_err_d;
    logic [W-1:0]      step_value;
    logic [W-1:0]      max_clamped;
    logic [DIGITS-1:0] carry_chain, borrow_chain;
    logic [ExtW-1:0]   value_ext, max_ext, load_ext, min_ext;
    logic              load_digits_ok, load_ok;
    logic              inc_req, dec_req, step_up, step_dn;

    assign value_ext = ExtW'(value_q);
    assign max_ext   = ExtW'(max_i);
    assign load_ext  = ExtW'(load_value_i);
    assign min_ext   = MinBcdFull;

    assign at_max_o = !bcd_lt(value_ext, max_ext);
    assign at_min_o = !bcd_lt(min_ext, value_ext);

    always_comb begin
        load_digits_ok = 1'b1;
        max_clamped    = max_i;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_value_i[NibbleW*k +: NibbleW] > DigitMax) begin
                load_digits_ok = 1'b0;
            end
            // Keeps a wrap-to-ceiling legal BCD even if the ceiling is not.
            if (max_i[NibbleW*k +: NibbleW] > DigitMax) begin
                max_clamped[NibbleW*k +: NibbleW] = DigitMax;
            end
        end
    end

    assign load_ok = load_digits_ok && !bcd_lt(load_ext, min_ext) && !bcd_lt(max_ext, load_ext);

    assign inc_req = !load_i && inc_i && !dec_i;
    assign dec_req = !load_i && dec_i && !inc_i;
    assign step_up = inc_req && !at_max_o;
    assign step_dn = dec_req && !at_min_o;

    assign carry_o  = inc_req && at_max_o && (WRAP != 0);
    assign borrow_o = dec_req && at_min_o && (WRAP != 0);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic cin, bin;
        if (k == 0) begin : g_lsd
            assign cin = step_up;
            assign bin = step_dn;
        end else begin : g_upper
            assign cin = carry_chain[k-1];
            assign bin = borrow_chain[k-1];
        end
        bcd_nibble_step u_step (
            .digit_i  (value_q[NibbleW*k +: NibbleW]),
            .carry_i  (cin),
            .borrow_i (bin),
            .digit_o  (step_value[NibbleW*k +: NibbleW]),
            .carry_o  (carry_chain[k]),
            .borrow_o (borrow_chain[k])
        );
    end

    // A step is only taken strictly inside the limits, so the top digit never overflows.
    logic unused_msd_overflow;
    assign unused_msd_overflow = carry_chain[DIGITS-1] ^ borrow_chain[DIGITS-1];

    always_comb begin
        value_d    = value_q;
        load_err_d = 1'b0;
        if (load_i) begin
            if (load_ok) begin
                value_d = load_value_i;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step_up || step_dn) begin
            value_d = step_value;
        end else if (carry_o) begin
            value_d = MinBcd;
        end else if (borrow_o) begin
            value_d = max_clamped;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q    <= MinBcd;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            load_err_q <= load_err_d;
        end
    end

    assign value_o    = value_q;
    assign load_err_o = load_err_q;

endmodule

// File: doc/bcd_field_counter.md
BCD_FIELD_COUNTER -- requirements
Module: bcd_field_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of BCD digits; legal values 1..4.
REQ-002 SHALL have parameter MIN_VALUE, default 0: decimal floor of the field, for example 1 for day or month.
REQ-003 SHALL have parameter WRAP, default 1: 1 means wrap at the limits, 0 means saturate at the limits.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port inc_i, input, 1 bit: increment request for this cycle.
REQ-007 SHALL have port dec_i, input, 1 bit: decrement request for this cycle.
REQ-008 SHALL have port load_i, input, 1 bit: load request for this cycle.
REQ-009 SHALL have port load_value_i, input, 4*DIGITS bits: BCD value to load; digit 0 is in the least-significant nibble.
REQ-010 SHALL have port max_i, input, 4*DIGITS bits: runtime BCD ceiling, for example 59, 23, or 28..31.
REQ-011 SHALL have port value_o, output, 4*DIGITS bits: current BCD value, taken directly from the register.
REQ-012 SHALL have port at_max_o, output, 1 bit: high when value is at or above max_i.
REQ-013 SHALL have port at_min_o, output, 1 bit: high when value is at or below MIN_VALUE.
REQ-014 SHALL have port carry_o, output, 1 bit: combinational; high when an accepted increment wraps this cycle.
REQ-015 SHALL have port borrow_o, output, 1 bit: combinational; high when an accepted decrement wraps this cycle.
REQ-016 SHALL have port load_err_o, output, 1 bit: registered one-cycle pulse flagging a rejected load.

Function
REQ-017 SHALL apply this priority each cycle: load_i, then inc_i XOR dec_i, then hold.
REQ-018 SHALL treat inc_i and dec_i high together without load_i as no operation; the value is held and carry_o and borrow_o stay 0.
REQ-019 SHALL accept a load only if every nibble is at most 9 and MIN_VALUE <= load_value_i <= max_i.
REQ-020 SHALL, for a rejected load, keep the value unchanged and pulse load_err_o high in the following cycle.
REQ-021 SHALL, on increment with value below max_i, set value to the next BCD value, with each nibble rolling 9 to 0 and carrying into the next nibble.
REQ-022 SHALL, on increment with value at or above max_i and WRAP=1, set value to MIN_VALUE and drive carry_o high in the same cycle.
REQ-023 SHALL, on increment with value at or above max_i and WRAP=0, hold the value and keep carry_o at 0.
REQ-024 SHALL, on decrement with value above MIN_VALUE, set value to the previous BCD value, with each nibble rolling 0 to 9 and borrowing from the next nibble.
REQ-025 SHALL, on decrement with value at or below MIN_VALUE and WRAP=1, set value to max_i and drive borrow_o high in the same cycle.
REQ-026 SHALL, on decrement with value at or below MIN_VALUE and WRAP=0, hold the value and keep borrow_o at 0.
REQ-027 SHALL ignore a value above a lowered max_i until it is stepped: the next increment wraps per REQ-022, and at_max_o is high in the meantime.
REQ-028 SHALL force carry_o and borrow_o to 0 in any cycle where load_i is high.
REQ-029 SHALL compare the BCD value and max_i digit-wise, most-significant nibble first; no binary conversion.
REQ-030 SHALL have zero-cycle latency from inc_i or dec_i to carry_o or borrow_o, so that cascaded instances step in the same cycle.
REQ-031 SHALL not deliberately guard against an out-of-range max_i (below MIN_VALUE or with a nibble above 9); the value stays a legal BCD code, but its sequence is the bench's responsibility.

Reset
REQ-032 SHALL, while rst_ni is low, asynchronously set value_o to MIN_VALUE in BCD and load_err_o to 0.
REQ-033 SHALL give carry_o and borrow_o a reset value of 0, as they depend on inc_i, dec_i and the registered value.
REQ-034 SHALL release reset synchronously to clk_i; the first operation is taken on the first rising edge with rst_ni high.
REQ-035 SHALL abandon any operation in progress when reset is asserted, with no partial update.

Structure
REQ-036 SHALL put the BCD nibble width (4), the digit maximum (9) and a function converting an integer parameter to BCD in the shared clock package.
REQ-037 SHALL use one sub-module, bcd_nibble_step: one nibble plus carry/borrow in, next nibble plus carry/borrow out; instantiated DIGITS times by generate.
REQ-038 SHALL contain no other state than the value register and the load_err register.

Verification
REQ-039 SHALL cover: DIGITS=2, MIN=0, max_i=59, value 59, inc_i for one cycle -> value 00 and carry_o high that cycle.
REQ-040 SHALL cover: DIGITS=2, MIN=1, max_i=31, value 01, dec_i -> value 31 and borrow_o high; repeat with WRAP=0 -> value 01 and borrow_o 0.
REQ-041 SHALL cover: load_value_i=0x3A, then 0x64 with max_i=59 -> both rejected, value unchanged, load_err_o pulses once each; load 0x42 -> value 42.
REQ-042 SHALL cover: value 30, then max_i changed from 31 to 28 -> at_max_o high at once; next inc_i -> value 01 with carry_o high.
REQ-043 SHALL cover: load_i, inc_i and dec_i all high together -> load wins and carry_o=0; inc_i and dec_i both high -> value held.
REQ-044 SHALL cover: rst_ni pulled low mid-cycle with inc_i high -> value_o goes to MIN_VALUE at once, with no clock edge needed.
